uplink_keycode_sender: RTL and testbench
========================================

// Module: uplink_keycode_sender
// PURPOSE
//  Upstream stimulus stage for the A19 uplink inputs UPL0/UPL1: serializes DSKY keycodes into uplink bit pulses.
//  Accepts one 5-bit keycode per valid/ready handshake and builds the 16-bit uplink word {1, C, ~C, C}.
//  Emits that word MSB-first as one-hot pulses: UPL1 for a 1 bit, UPL0 for a 0 bit.
//  Honors BLKUPL, the uplink block from A19, by deferring bit starts. Used in benches and in full-system sims.
// PARAMETERS
//  BIT_CLKS    160  CLOCK cycles per bit cell (pulse + space); must be > PULSE_CLKS
//  PULSE_CLKS  4    CLOCK cycles a UPL0/UPL1 pulse stays high; must be >= 1
//  GAP_CLKS    320  idle CLOCK cycles after bit 0 before the next keycode is accepted; may be 0
// PORTS
//  CLOCK      in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  key_code   in   5  DSKY keycode C
//  key_valid  in   1  key_code is valid
//  key_ready  out  1  sender can accept; high only in IDLE
//  BLKUPL     in   1  uplink block from A19; high defers the next bit start
//  UPL0       out  1  zero-bit pulse, to A19 UPL0
//  UPL1       out  1  one-bit pulse, to A19 UPL1
//  busy       out  1  high in every state except IDLE
//  word_done  out  1  one-cycle strobe on the cycle that GAP is entered
// BEHAVIOUR
//  Reset: state=IDLE; UPL0=UPL1=busy=word_done=0; key_ready=1 from the first cycle after rst falls.
//  Accept: key_valid&key_ready at edge N latches word W={1'b1,C,~C,C} into the shift register.
//   Bit index starts at 15.
//  States:
//   IDLE   -> PULSE on accept; if BLKUPL=1 at accept -> HOLD instead.
//   PULSE  drives UPL1=W[idx], UPL0=~W[idx] for PULSE_CLKS cycles, then -> SPACE.
//   SPACE  drives both UPLs low for BIT_CLKS-PULSE_CLKS cycles. At its end:
//          idx==0 -> GAP, pulsing word_done;
//          else idx-- and -> PULSE if BLKUPL=0, else -> HOLD.
//   HOLD   both UPLs low, no counting; -> PULSE on the first cycle BLKUPL=0.
//   GAP    both UPLs low for GAP_CLKS cycles (GAP_CLKS=0: one cycle), then -> IDLE.
//  UPL0 and UPL1 are registered outputs. They are never high together, and each is high for exactly PULSE_CLKS cycles per bit.
//  A pulse in progress always completes: BLKUPL is sampled only at bit starts.
//  Latency with BLKUPL=0 throughout:
//   first pulse is visible from edge N+1;
//   key_ready returns at edge N+1+16*BIT_CLKS+max(GAP_CLKS,1).
//  key_valid while busy is ignored; the held key_code is not sampled.
//  rst mid-word: at the next edge all outputs go to 0 and state goes to IDLE. The partial word is discarded.
//  Counters: one down-counter of width $clog2(max(BIT_CLKS,GAP_CLKS)+1) and one 4-bit index.
//   Neither counter wraps; terminal count is detected at 1.
// CONFIGURATION
//  UPLINK_ERRINJ_EN defined: adds ports err_inj (in, 1) and err_inj_bit (in, 4).
//   If err_inj=1 at accept, bit W[err_inj_bit] is inverted before transmission.
//   This exercises A19/software triple-redundancy checking. word_done and timing are unchanged.
//  Undefined: those ports do not exist, and W is always the exact encoding.
// STRUCTURE
//  Package agc_uplink_pkg holds:
//   - typedef enum upl_state_t {IDLE, PULSE, SPACE, HOLD, GAP};
//   - localparam UPL_WORD_W=16;
//   - function upl_encode(input [4:0] c) returning {1'b1,c,~c,c}.
//  Sub-module uplink_bit_timer: loadable down-counter with load value, enable and terminal flag.
//   One instance is shared by PULSE, SPACE and GAP.
// TESTING
//  1 C=5'b10101, BLKUPL=0: serial word is 0xD555, with 9 UPL1 and 7 UPL0 pulses, each 4 cycles wide.
//    Pulse leading edges are 160 cycles apart; key_ready returns 2881 cycles after accept.
//  2 C=5'b00000: serial word is 0x83E0, with 6 UPL1 and 10 UPL0 pulses.
//    word_done fires once, 2561 cycles after accept.
//  3 BLKUPL raised during the bit-12 pulse and held 500 cycles:
//    the bit-12 pulse completes at full width, the bit-11 pulse is deferred until BLKUPL falls,
//    and the total word time grows by the held cycles.
//  4 rst asserted during bit 7: next edge UPL0=UPL1=busy=0, key_ready=1.
//    A new keycode 5'b11111 then sends 0xFC1F in full.
//  5 key_valid held high with a changing key_code while busy: only the first code is sent.
//    A second accept occurs exactly when key_ready returns.
//  6 UPLINK_ERRINJ_EN defined, C=5'b10101, err_inj=1, err_inj_bit=3: sent word is 0xD55D.
//    The same run without the macro sends 0xD555.

Source files
------------

// File: rtl/uplink_keycode_sender_pkg.sv
// Shared state type, word width and keycode-to-uplink-word encoding.
package agc_uplink_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    SPACE = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } upl_state_t;

  localparam int UPL_WORD_W = 16;

  // Triple-redundant uplink word: marker bit, then C, ~C, C.
  function automatic logic [UPL_WORD_W-1:0] upl_encode(input logic [4:0] c);
    return {1'b1, c, ~c, c};
  endfunction
endpackage

// File: rtl/uplink_keycode_sender_if.sv
// Keycode valid/ready handshake between a key source and the uplink sender.
interface uplink_key_if;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/uplink_keycode_sender_bit_timer.sv
// Loadable, non-wrapping down-counter; term flags the last counted cycle (count == 1).
module uplink_bit_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         term
);
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - W'(1);
  end

  assign term = (count == W'(1));
endmodule

// File: rtl/uplink_keycode_sender.sv
// Serializes DSKY keycodes into one-hot UPL1/UPL0 bit pulses, MSB first, deferring bit starts while BLKUPL is high.
// Optional UPLINK_ERRINJ_EN adds err_inj/err_inj_bit to flip one word bit at accept.
module uplink_keycode_sender
  import agc_uplink_pkg::*;
#(
  parameter int BIT_CLKS   = 160,
  parameter int PULSE_CLKS = 4,
  parameter int GAP_CLKS   = 320
) (
  input  logic       CLOCK,
  input  logic       rst,
  uplink_key_if.slave key,
  input  logic       BLKUPL,
`ifdef UPLINK_ERRINJ_EN
  input  logic       err_inj,
  input  logic [3:0] err_inj_bit,
`endif
  output logic       UPL0,
  output logic       UPL1,
  output logic       busy,
  output logic       word_done
);
  localparam int CNT_MAX = (BIT_CLKS > GAP_CLKS) ? BIT_CLKS : GAP_CLKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CLKS);
  localparam logic [CW-1:0] SPACE_LD = CW'(BIT_CLKS - PULSE_CLKS);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CLKS > 0) ? GAP_CLKS : 1);

  upl_state_t            state, state_nxt;
  logic [3:0]            idx;
  logic [UPL_WORD_W-1:0] word, enc_word;
  logic                  accept;
  logic                  t_load, t_en, t_term;
  logic [CW-1:0]         t_ld_val, t_count;

`ifdef UPLINK_ERRINJ_EN
  assign enc_word = upl_encode(key.key_code) ^
                    (err_inj ? (UPL_WORD_W'(1) << err_inj_bit) : '0);
`else
  assign enc_word = upl_encode(key.key_code);
`endif

  assign accept = key.key_valid & key.key_ready;
  assign busy   = (state != IDLE);

  uplink_bit_timer #(.W(CW)) u_timer (
    .clk      (CLOCK),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_ld_val),
    .en       (t_en),
    .count    (t_count),
    .term     (t_term)
  );

  // BLKUPL only matters at bit starts; a running pulse/space always completes.
  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_ld_val  = PULSE_LD;
    t_en      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (BLKUPL) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = PULSE;
            t_load    = 1'b1;
          end
        end
      end
      PULSE: begin
        t_en = 1'b1;
        if (t_term) begin
          state_nxt = SPACE;
          t_load    = 1'b1;
          t_ld_val  = SPACE_LD;
        end
      end
      SPACE: begin
        t_en = 1'b1;
        if (t_term) begin
          if (idx == 4'd0) begin
            state_nxt = GAP;
            t_load    = 1'b1;
            t_ld_val  = GAP_LD;
          end else if (BLKUPL) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = PULSE;
            t_load    = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!BLKUPL) begin
          state_nxt = PULSE;
          t_load    = 1'b1;
        end
      end
      GAP: begin
        t_en = 1'b1;
        if (t_term) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      word          <= '0;
      key.key_ready <= 1'b1;
      UPL0          <= 1'b0;
      UPL1          <= 1'b0;
      word_done     <= 1'b0;
    end else begin
      state         <= state_nxt;
      key.key_ready <= (state == IDLE) && !accept;
      if (accept) begin
        word <= enc_word;
        idx  <= 4'd15;
      end else if (state == SPACE && t_term && idx != 4'd0) begin
        idx <= idx - 4'd1;
      end
      UPL1      <= (state == PULSE) && word[idx];
      UPL0      <= (state == PULSE) && !word[idx];
      // Counter still holds its load value only on the first GAP cycle.
      word_done <= (state == GAP) && (t_count == GAP_LD);
    end
  end
endmodule

// File: tb/tb_uplink_keycode_sender.sv
// Randomized bench for uplink_keycode_sender: timeline reference model plus literal word/timing checks.
module tb_uplink_keycode_sender;
  localparam int BIT_CLKS   = 160;
  localparam int PULSE_CLKS = 4;
  localparam int GAP_CLKS   = 320;
  localparam int GAP_LEN    = (GAP_CLKS > 0) ? GAP_CLKS : 1;
  localparam int WAIT_MAX   = 20000;

  logic CLOCK, rst, blk;
  logic UPL0, UPL1, busy, word_done;
`ifdef UPLINK_ERRINJ_EN
  logic       err_inj;
  logic [3:0] err_inj_bit;
`endif

  uplink_key_if kif ();

  uplink_keycode_sender dut (
    .CLOCK       (CLOCK),
    .rst         (rst),
    .key         (kif),
    .BLKUPL      (blk),
`ifdef UPLINK_ERRINJ_EN
    .err_inj     (err_inj),
    .err_inj_bit (err_inj_bit),
`endif
    .UPL0        (UPL0),
    .UPL1        (UPL1),
    .busy        (busy),
    .word_done   (word_done)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  function automatic logic [15:0] ref_word(input logic [4:0] c);
    int v;
    v = 32768 + int'(c) * 1024 + (31 - int'(c)) * 32 + int'(c);
    return 16'(v);
  endfunction

  // Reference timeline: absolute edge numbers for bit starts, gap entry and idle return.
  bit          mvalid = 0;
  bit          m_active, m_ready, was_active, acc;
  logic [15:0] m_word;
  int          m_bit, m_cand, m_start, m_gap;
  logic        e_upl0, e_upl1, e_busy, e_done, e_ready;

  always @(posedge CLOCK) begin
    cyc = cyc + 1;
    if (rst) begin
      mvalid = 1; m_active = 0; m_ready = 1;
      m_start = -1; m_cand = -1; m_gap = -1; m_bit = 0; m_word = '0;
    end else if (mvalid) begin
      was_active = m_active;
      acc = !was_active && m_ready && kif.key_valid;
      if (was_active) begin
        if (m_gap >= 0) begin
          if (cyc == m_gap + GAP_LEN) m_active = 0;
        end else if (m_start >= 0 && cyc == m_start + BIT_CLKS) begin
          if (m_bit == 0) m_gap = cyc;
          else begin m_bit = m_bit - 1; m_cand = cyc; m_start = -1; end
        end
      end
      if (acc) begin
        m_word = ref_word(kif.key_code);
`ifdef UPLINK_ERRINJ_EN
        if (err_inj) m_word[err_inj_bit] = ~m_word[err_inj_bit];
`endif
        m_bit = 15; m_cand = cyc; m_start = -1; m_gap = -1; m_active = 1;
      end
      if (m_cand >= 0 && !blk) begin m_start = cyc; m_cand = -1; end
      m_ready = !was_active && !acc;
    end
    e_upl1  = m_active && m_gap < 0 && m_start >= 0 && cyc >= m_start + 1 &&
              cyc <= m_start + PULSE_CLKS && m_word[m_bit];
    e_upl0  = m_active && m_gap < 0 && m_start >= 0 && cyc >= m_start + 1 &&
              cyc <= m_start + PULSE_CLKS && !m_word[m_bit];
    e_busy  = m_active;
    e_done  = (m_gap >= 0) && (cyc == m_gap + 1);
    e_ready = m_ready;
  end

  always @(negedge CLOCK) begin
    if (mvalid) begin
      tests = tests + 1;
      if ({UPL0, UPL1, busy, word_done, kif.key_ready} !== {e_upl0, e_upl1, e_busy, e_done, e_ready}) begin
        fails = fails + 1;
        $display("FAIL cycle_model cyc=%0d upl0/upl1/busy/done/ready got=%b%b%b%b%b required=%b%b%b%b%b",
                 cyc, UPL0, UPL1, busy, word_done, kif.key_ready, e_upl0, e_upl1, e_busy, e_done, e_ready);
      end
    end
  end

  // Pulse capture for the literal checks.
  logic [15:0] cap_word;
  logic        p1 = 0, p0 = 0;
  int cap_n, cap_ones, cur_w, w_min, w_max, rise_last, sp_min, sp_max, done_cnt, done_cyc;

  always @(negedge CLOCK) begin
    if (mvalid) begin
      if ((UPL1 && !p1) || (UPL0 && !p0)) begin
        cap_word = {cap_word[14:0], UPL1};
        cap_n    = cap_n + 1;
        if (UPL1) cap_ones = cap_ones + 1;
        if (rise_last >= 0) begin
          if (cyc - rise_last < sp_min) sp_min = cyc - rise_last;
          if (cyc - rise_last > sp_max) sp_max = cyc - rise_last;
        end
        rise_last = cyc;
        cur_w     = 0;
      end
      if (UPL0 || UPL1) cur_w = cur_w + 1;
      if ((p1 && !UPL1) || (p0 && !UPL0)) begin
        if (cur_w < w_min) w_min = cur_w;
        if (cur_w > w_max) w_max = cur_w;
      end
      if (word_done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
      p1 = UPL1;
      p0 = UPL0;
    end
  end

  task automatic clear_cap();
    cap_word = '0; cap_n = 0; cap_ones = 0; cur_w = 0;
    w_min = 1000000; w_max = 0; rise_last = -1;
    sp_min = 1000000; sp_max = 0; done_cnt = 0; done_cyc = -1;
  endtask

  task automatic check(input string name, input int got, input int req);
    tests = tests + 1;
    if (got != req) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic wait_ready(input bit rand_blk, output int t);
    int n;
    n = 0;
    while (kif.key_ready !== 1'b1 && n < WAIT_MAX) begin
      @(negedge CLOCK);
      n = n + 1;
      if (rand_blk) begin
        if (!blk) begin if ($urandom_range(299) == 0) blk = 1'b1; end
        else if ($urandom_range(39) == 0) blk = 1'b0;
      end
    end
    if (n >= WAIT_MAX) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL ready_timeout: key_ready still %b after %0d cycles", kif.key_ready, n);
    end
    t = cyc;
  endtask

  task automatic send(input logic [4:0] c, input bit hold_valid, output int t_acc);
    int t;
    wait_ready(1'b0, t);
    kif.key_code  = c;
    kif.key_valid = 1'b1;
    t_acc = cyc + 1;
    @(negedge CLOCK);
    if (!hold_valid) kif.key_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLOCK);
  endtask

  initial begin
    int t0, tr, tr2;
    logic [4:0] c, c2;
    rst = 1'b1; blk = 1'b0; kif.key_valid = 1'b0; kif.key_code = '0;
`ifdef UPLINK_ERRINJ_EN
    err_inj = 1'b0; err_inj_bit = '0;
`endif
    clear_cap();
    repeat (3) @(negedge CLOCK);
    rst = 1'b0;
    check("reset_ready", int'(kif.key_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_upl", int'(UPL0 | UPL1 | word_done), 0);

    // 10101, no blocking
    clear_cap();
    send(5'b10101, 1'b0, t0);
    wait_ready(1'b0, tr);
    check("t1_word", int'(cap_word), 16'hD555);
    check("t1_pulses", cap_n, 16);
    check("t1_ones", cap_ones, 9);
    check("t1_wmin", w_min, 4);
    check("t1_wmax", w_max, 4);
    check("t1_spmin", sp_min, 160);
    check("t1_spmax", sp_max, 160);
    check("t1_ready_lat", tr - t0, 2881);

    // 00000, word_done timing
    clear_cap();
    send(5'b00000, 1'b0, t0);
    wait_ready(1'b0, tr);
    check("t2_word", int'(cap_word), 16'h83E0);
    check("t2_ones", cap_ones, 6);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_lat", done_cyc - t0, 2561);

    // BLKUPL raised during the bit-12 pulse for 500 cycles
    clear_cap();
    send(5'b01101, 1'b0, t0);
    wait_cyc(t0 + 482);
    check("t3_in_pulse", int'(UPL0 | UPL1), 1);
    blk = 1'b1;
    repeat (500) @(negedge CLOCK);
    blk = 1'b0;
    wait_ready(1'b0, tr);
    check("t3_word", int'(cap_word), int'(ref_word(5'b01101)));
    check("t3_wmin", w_min, 4);
    check("t3_spmax", sp_max, 503);
    check("t3_ready_lat", tr - t0, 3224);

    // reset during bit 7, then a full word
    clear_cap();
    send(5'b01011, 1'b0, t0);
    wait_cyc(t0 + 1282);
    rst = 1'b1;
    @(negedge CLOCK);
    check("t4_rst_upl", int'(UPL0 | UPL1), 0);
    check("t4_rst_busy", int'(busy), 0);
    check("t4_rst_ready", int'(kif.key_ready), 1);
    rst = 1'b0;
    @(negedge CLOCK);
    clear_cap();
    send(5'b11111, 1'b0, t0);
    wait_ready(1'b0, tr);
    check("t4_word", int'(cap_word), 16'hFC1F);
    check("t4_ones", cap_ones, 11);
    check("t4_ready_lat", tr - t0, 2881);

    // key_valid held with a wandering key_code while busy
    clear_cap();
    send(5'b00110, 1'b1, t0);
    for (int n = 0; n < WAIT_MAX && kif.key_ready !== 1'b1; n++) begin
      kif.key_code = 5'($urandom);
      @(negedge CLOCK);
    end
    tr = cyc;
    check("t5_word1", int'(cap_word), int'(ref_word(5'b00110)));
    check("t5_ready_lat", tr - t0, 2881);
    c2 = 5'b11001;
    kif.key_code = c2;
    clear_cap();
    @(negedge CLOCK);
    check("t5_second_accept_ready", int'(kif.key_ready), 0);
    check("t5_second_accept_busy", int'(busy), 1);
    kif.key_valid = 1'b0;
    wait_ready(1'b0, tr2);
    check("t5_word2", int'(cap_word), int'(ref_word(c2)));
    check("t5_ready_lat2", tr2 - (tr + 1), 2881);

    // random keycodes with random BLKUPL bursts
    for (int k = 0; k < 6; k++) begin
      c = 5'($urandom);
`ifdef UPLINK_ERRINJ_EN
      err_inj = 1'($urandom); err_inj_bit = 4'($urandom);
`endif
      clear_cap();
      send(c, 1'b0, t0);
      wait_ready(1'b1, tr);
      check("rand_pulses", cap_n, 16);
      check("rand_wmin", w_min, 4);
      check("rand_done_cnt", done_cnt, 1);
    end
    blk = 1'b0;

`ifdef UPLINK_ERRINJ_EN
    err_inj = 1'b1; err_inj_bit = 4'd3;
    clear_cap();
    send(5'b10101, 1'b0, t0);
    err_inj = 1'b0;
    wait_ready(1'b0, tr);
    check("t6_errinj_word", int'(cap_word), 16'hD55D);
    check("t6_ready_lat", tr - t0, 2881);
`endif

    repeat (4) @(negedge CLOCK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
